keypad_scanner: RTL and testbench

- Upstream front end for the gencon calculator controller.
- Scans a 4x4 matrix keypad, synchronises and debounces the column lines, and decodes one key per press.
- Drives gencon's digit/read_input handshake and its operator_input/equal_input pulses, so that exactly one gencon event is issued per physical key press.

---
 rtl/keypad_defs.sv | 41 ++++
 rtl/keypad_decode.sv | 36 +++
 rtl/keypad_scanner.sv | 142 ++++++++++++++
 tb/tb_keypad_scanner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_defs.sv
// Shared types and encodings for the keypad scanner front end and its decoder.
// Operator codes must stay identical to gencon's operator_input encoding.
package keypad_defs;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    RELEASE
  } scan_state_t;

  typedef enum logic [1:0] {
    KEY_DIGIT,
    KEY_OP,
    KEY_EQ,
    KEY_NONE
  } key_action_t;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational key map: (row, col) of the 4x4 pad -> action, BCD digit, opcode.
// Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
module keypad_decode
  import keypad_defs::*;
(
  input  logic [1:0]  row_i,
  input  logic [1:0]  col_i,
  output key_action_t action_o,
  output logic [3:0]  digit_o,
  output logic [2:0]  opcode_o
);

  always_comb begin
    action_o = KEY_NONE;
    digit_o  = 4'd0;
    opcode_o = OP_NONE;
    if (col_i == 2'd3) begin
      case (row_i)
        2'd0: begin action_o = KEY_OP; opcode_o = OP_ADD; end
        2'd1: begin action_o = KEY_OP; opcode_o = OP_SUB; end
        2'd2: begin action_o = KEY_OP; opcode_o = OP_MUL; end
        default: action_o = KEY_NONE;
      endcase
    end else if (row_i != 2'd3) begin
      action_o = KEY_DIGIT;
      digit_o  = ({2'b00, row_i} * 4'd3) + {2'b00, col_i} + 4'd1;
    end else begin
      case (col_i)
        2'd0: begin action_o = KEY_OP; opcode_o = OP_NEG; end
        2'd1: begin action_o = KEY_DIGIT; digit_o = 4'd0; end
        default: action_o = KEY_EQ;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, column sync + debounce, one gencon event per press.
// The internal state_q register is the FSM state for debug/checker binding.
module keypad_scanner
  import keypad_defs::*;
#(
  parameter int SCAN_DWELL      = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       nRST,
  output logic [3:0] keypad_row,
  input  logic [3:0] keypad_col,
  input  logic       key_read,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input
);

  localparam int DW = $clog2(SCAN_DWELL) + 1;
  localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int AW = $clog2(ACK_TIMEOUT) + 1;

  scan_state_t state_q;
  logic [3:0]  col_meta_q, col_s_q;
  logic [1:0]  row_q, col_q;
  logic [DW-1:0] dwell_q;
  logic [BW-1:0] db_q;
  logic [AW-1:0] ack_q;
  logic [3:0]  kin_q;
  logic        read_q, eq_q;
  logic [2:0]  op_q;

  key_action_t action;
  logic [3:0]  digit;
  logic [2:0]  opcode;
  logic [3:0]  col_mask;

  keypad_decode u_decode (
    .row_i    (row_q),
    .col_i    (col_q),
    .action_o (action),
    .digit_o  (digit),
    .opcode_o (opcode)
  );

  assign col_mask       = 4'b0001 << col_q;
  assign keypad_row     = 4'b0001 << row_q;
  assign keypad_input   = kin_q;
  assign read_input     = read_q;
  assign operator_input = op_q;
  assign equal_input    = eq_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      col_meta_q <= 4'd0;
      col_s_q    <= 4'd0;
    end else begin
      col_meta_q <= keypad_col;
      col_s_q    <= col_meta_q;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= SCAN;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      dwell_q <= '0;
      db_q    <= '0;
      ack_q   <= '0;
      kin_q   <= 4'd0;
      read_q  <= 1'b0;
      op_q    <= OP_NONE;
      eq_q    <= 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (dwell_q == DW'(SCAN_DWELL - 1)) begin
            dwell_q <= '0;
            // Ghosted or multi-key samples are skipped rather than guessed at.
            if (is_onehot(col_s_q)) begin
              col_q   <= onehot_idx(col_s_q);
              state_q <= DEBOUNCE;
            end else begin
              row_q <= row_q + 2'd1;
            end
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s_q != col_mask) begin
            db_q    <= '0;
            state_q <= SCAN;
          end else if (db_q == BW'(DEBOUNCE_CYCLES - 1)) begin
            db_q    <= '0;
            state_q <= EMIT;
            case (action)
              KEY_DIGIT: begin kin_q <= digit; read_q <= 1'b1; end
              KEY_OP:    op_q <= opcode;
              KEY_EQ:    eq_q <= 1'b1;
              default:   ;
            endcase
          end else begin
            db_q <= db_q + BW'(1);
          end
        end
        EMIT: begin
          op_q <= OP_NONE;
          eq_q <= 1'b0;
          if (read_q) begin
            if (key_read || (ack_q == AW'(ACK_TIMEOUT - 1))) begin
              read_q  <= 1'b0;
              kin_q   <= 4'd0;
              ack_q   <= '0;
              state_q <= RELEASE;
            end else begin
              ack_q <= ack_q + AW'(1);
            end
          end else begin
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (col_s_q != 4'd0) begin
            db_q <= '0;
          end else if (db_q == BW'(DEBOUNCE_CYCLES - 1)) begin
            db_q    <= '0;
            row_q   <= row_q + 2'd1;
            state_q <= SCAN;
          end else begin
            db_q <= db_q + BW'(1);
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives columns from the row
// drive; a negedge monitor reassembles gencon events and checks them against exp_q.
module tb_keypad_scanner;

  localparam int SCAN_DWELL      = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int ACK_TIMEOUT     = 10;

  localparam logic [3:0] EV_DIG = 4'd1;
  localparam logic [3:0] EV_OP  = 4'd2;
  localparam logic [3:0] EV_EQ  = 4'd3;

  logic       clk = 1'b0;
  logic       nRST;
  logic [3:0] keypad_row;
  logic [3:0] keypad_col;
  logic       key_read;
  logic [3:0] keypad_input;
  logic       read_input;
  logic [2:0] operator_input;
  logic       equal_input;

  logic [15:0] keys;
  int          ack_mode;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];

  keypad_scanner #(
    .SCAN_DWELL      (SCAN_DWELL),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACK_TIMEOUT     (ACK_TIMEOUT)
  ) dut (
    .clk            (clk),
    .nRST           (nRST),
    .keypad_row     (keypad_row),
    .keypad_col     (keypad_col),
    .key_read       (key_read),
    .keypad_input   (keypad_input),
    .read_input     (read_input),
    .operator_input (operator_input),
    .equal_input    (equal_input)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- keypad matrix model ----------------
  always_comb begin
    keypad_col = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && keypad_row[r]) keypad_col[c] = 1'b1;
  end

  // ---------------- gencon acknowledge driver ----------------
  // mode 0: tied low, mode 1: tied high, mode 2: ack 2 cycles after read rises
  int rd_cnt = 0;
  always @(negedge clk) begin
    if (read_input) rd_cnt = rd_cnt + 1;
    else            rd_cnt = 0;
    case (ack_mode)
      0:       key_read = 1'b0;
      1:       key_read = 1'b1;
      default: key_read = (rd_cnt >= 3);
    endcase
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] ev(input logic [3:0] t, input logic [3:0] v,
                                     input logic [7:0] len);
    return {t, v, len};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_event(input logic [15:0] obs);
    logic [15:0] want;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected event: got %h want none", obs);
    end else begin
      want = exp_q.pop_front();
      if (obs !== want) begin
        miscompares++;
        $display("FAIL event: got %h want %h", obs, want);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       in_rd = 1'b0, in_op = 1'b0, in_eq = 1'b0;
  int         rd_len, op_len, eq_len;
  logic [3:0] rd_val, op_val;
  int         excl_err = 0, kin_err = 0, wraps = 0;
  logic [3:0] prev_row = 4'd0;

  always @(negedge clk) begin
    if (!nRST) begin
      in_rd = 1'b0;
      in_op = 1'b0;
      in_eq = 1'b0;
    end else begin
      if (read_input) begin
        if (!in_rd) begin in_rd = 1'b1; rd_len = 0; rd_val = keypad_input; end
        rd_len++;
      end else if (in_rd) begin
        in_rd = 1'b0;
        check_event(ev(EV_DIG, rd_val, 8'(rd_len)));
      end
      if (operator_input != 3'd0) begin
        if (!in_op) begin in_op = 1'b1; op_len = 0; op_val = {1'b0, operator_input}; end
        op_len++;
      end else if (in_op) begin
        in_op = 1'b0;
        check_event(ev(EV_OP, op_val, 8'(op_len)));
      end
      if (equal_input) begin
        if (!in_eq) begin in_eq = 1'b1; eq_len = 0; end
        eq_len++;
      end else if (in_eq) begin
        in_eq = 1'b0;
        check_event(ev(EV_EQ, 4'd0, 8'(eq_len)));
      end
      if ((int'(read_input) + int'(operator_input != 3'd0) + int'(equal_input)) > 1)
        excl_err++;
      if (!read_input && keypad_input != 4'd0) kin_err++;
    end
    if (prev_row == 4'b1000 && keypad_row == 4'b0001) wraps++;
    prev_row = keypad_row;
  end

  // ---------------- driver tasks ----------------
  task automatic press(input int r, input int c, input int hold);
    @(negedge clk);
    keys[r*4+c] = 1'b1;
    repeat (hold) @(negedge clk);
    keys = 16'd0;
    repeat (40) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int n;
    nRST     = 1'b1;
    keys     = 16'd0;
    ack_mode = 2;
    key_read = 1'b0;
    #1 nRST  = 1'b0;
    keys[5]  = 1'b1;  // '5' held through reset

    repeat (3) @(negedge clk);
    check("reset keypad_row", keypad_row, 4'b0001);
    check("reset read_input", read_input, 1'b0);
    check("reset keypad_input", keypad_input, 4'd0);
    check("reset operator_input", operator_input, 3'd0);
    check("reset equal_input", equal_input, 1'b0);

    // '5': ack 2 cycles after read rises -> read high 3 cycles, held 150 -> one event
    exp_q.push_back(ev(EV_DIG, 4'd5, 8'd3));
    nRST = 1'b1;
    @(negedge clk);
    check("row0 after reset", keypad_row, 4'b0001);
    repeat (150) @(negedge clk);
    keys = 16'd0;
    repeat (40) @(negedge clk);
    wait_drain("drain key5");

    // bouncy '#': toggles every 3 cycles for 20 cycles, then stable
    ack_mode = 1;
    exp_q.push_back(ev(EV_EQ, 4'd0, 8'd1));
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) keys[14] = ~keys[14];
      @(negedge clk);
    end
    keys[14] = 1'b1;
    repeat (60) @(negedge clk);
    keys = 16'd0;
    repeat (40) @(negedge clk);
    wait_drain("drain bouncy hash");

    // sequence * 1 2 A 3 # with key_read tied high
    exp_q.push_back(ev(EV_OP,  4'd1, 8'd1)); press(3, 0, 60);
    exp_q.push_back(ev(EV_DIG, 4'd1, 8'd1)); press(0, 0, 60);
    exp_q.push_back(ev(EV_DIG, 4'd2, 8'd1)); press(0, 1, 60);
    exp_q.push_back(ev(EV_OP,  4'd2, 8'd1)); press(0, 3, 60);
    exp_q.push_back(ev(EV_DIG, 4'd3, 8'd1)); press(0, 2, 60);
    exp_q.push_back(ev(EV_EQ,  4'd0, 8'd1)); press(3, 2, 60);
    wait_drain("drain sequence");

    // other operators: B -> sub, C -> mul
    exp_q.push_back(ev(EV_OP, 4'd3, 8'd1)); press(1, 3, 60);
    exp_q.push_back(ev(EV_OP, 4'd4, 8'd1)); press(2, 3, 60);
    wait_drain("drain ops");

    // '7' never acknowledged -> read held exactly ACK_TIMEOUT cycles; then '8' accepted
    ack_mode = 0;
    exp_q.push_back(ev(EV_DIG, 4'd7, 8'd10)); press(2, 0, 60);
    ack_mode = 1;
    exp_q.push_back(ev(EV_DIG, 4'd8, 8'd1)); press(2, 1, 60);
    wait_drain("drain timeout");

    // two keys in one row (col 0011): no event, scan keeps wrapping
    w0 = wraps;
    press(0, 0, 0);
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    repeat (100) @(negedge clk);
    keys = 16'd0;
    repeat (40) @(negedge clk);
    check("row wrap 3->0", int'(wraps > w0), 1);

    // D: debounced, no outputs; '0' still accepted afterwards
    press(3, 3, 60);
    exp_q.push_back(ev(EV_DIG, 4'd0, 8'd1)); press(3, 1, 60);
    wait_drain("drain d then 0");

    // reset in the middle of a pending read; held key re-emits once after reset
    ack_mode = 0;
    @(negedge clk);
    keys[4] = 1'b1;
    n = 0;
    while (!read_input && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("read rises for key4", read_input, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 nRST = 1'b0;
    #1;
    check("mid reset read_input", read_input, 1'b0);
    check("mid reset keypad_input", keypad_input, 4'd0);
    check("mid reset keypad_row", keypad_row, 4'b0001);
    repeat (5) @(negedge clk);
    exp_q.push_back(ev(EV_DIG, 4'd4, 8'd10));
    nRST = 1'b1;
    repeat (100) @(negedge clk);
    keys = 16'd0;
    repeat (40) @(negedge clk);
    wait_drain("drain after mid reset");

    repeat (20) @(negedge clk);
    check("output exclusivity violations", excl_err, 0);
    check("keypad_input nonzero while idle", kin_err, 0);
    check("leftover expected events", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
